// File: rtl/xc_malu_muldiv_seq.sv
// Self-sequencing multi-cycle multiply/divide unit (RISC-V M ops) with valid/ready on both sides.
// Shift-add multiply retires MUL_UNROLL bits per cycle; restoring divide retires one quotient bit per cycle.
module xc_malu_muldiv_seq #(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW   = $clog2(XLEN) + 1;
    localparam int NMUL = XLEN / MUL_UNROLL;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              spec_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN:0]     rem_q;
    logic [CW-1:0]     cnt_q;

    logic              accept;
    logic              sg1, sg2, s1, s2, div0, ovf, special, neg;
    logic [XLEN-1:0]   mag1, mag2, spec_val;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == FIX);

    // Operand conditioning at accept: magnitudes, result sign and special cases.
    always_comb begin
        sg1      = !(op inside {3'b011, 3'b101, 3'b111});
        sg2      = sg1 && (op != 3'b010);
        s1       = sg1 && rs1[XLEN-1];
        s2       = sg2 && rs2[XLEN-1];
        mag1     = s1 ? -rs1 : rs1;
        mag2     = s2 ? -rs2 : rs2;
        neg      = (op[2] && op[1]) ? s1 : (s1 ^ s2);
        div0     = op[2] && (rs2 == '0);
        ovf      = (op == 3'b100 || op == 3'b110) && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        special  = div0 || ovf;
        spec_val = '0;
        if (div0)
            spec_val = op[1] ? rs1 : '1;
        else if (ovf)
            spec_val = op[1] ? '0 : rs1;
    end

    // Multiply step: add multiplicand times the low MUL_UNROLL multiplier bits, shift right.
    logic [XLEN+MUL_UNROLL-1:0] psum;
    logic [2*XLEN-1:0]          mul_nxt;
    always_comb begin
        psum = {{MUL_UNROLL{1'b0}}, acc_q[2*XLEN-1:XLEN]};
        for (int i = 0; i < MUL_UNROLL; i++)
            if (acc_q[i])
                psum = psum + ({{MUL_UNROLL{1'b0}}, opnd_q} << i);
        mul_nxt = {psum, acc_q[XLEN-1:MUL_UNROLL]};
    end

    // Restoring divide step; the dividend shifts out of acc_q while quotient bits shift in.
    logic [XLEN+1:0] shifted, diff;
    logic [XLEN:0]   rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    always_comb begin
        shifted = {rem_q, acc_q[XLEN-1]};
        diff    = shifted - {2'b00, opnd_q};
        if (!diff[XLEN+1]) begin
            rem_nxt = diff[XLEN:0];
            quo_nxt = {acc_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[XLEN:0];
            quo_nxt = {acc_q[XLEN-2:0], 1'b0};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fix_val;
    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        quo     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rmd     = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        fix_val = rmd;
        if (spec_q)
            fix_val = acc_q[XLEN-1:0];
        else case (op_q)
            3'b000:                 fix_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo;
            default:                fix_val = rmd;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = special ? FIX : CALC;
                else if (state == DONE && out_ready)
                    state_nxt = IDLE;
            end
            CALC:    if (cnt_q == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            spec_q <= 1'b0;
            opnd_q <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                op_q   <= op;
                neg_q  <= neg;
                spec_q <= special;
                rem_q  <= '0;
                cnt_q  <= op[2] ? CW'(XLEN - 1) : CW'(NMUL - 1);
                if (special) begin
                    acc_q  <= {{XLEN{1'b0}}, spec_val};
                    opnd_q <= '0;
                end else if (op[2]) begin
                    acc_q  <= {{XLEN{1'b0}}, mag1};
                    opnd_q <= mag2;
                end else begin
                    acc_q  <= {{XLEN{1'b0}}, mag2};
                    opnd_q <= mag1;
                end
            end else if (state == CALC) begin
                cnt_q <= cnt_q - CW'(1);
                if (op_q[2]) begin
                    acc_q[XLEN-1:0] <= quo_nxt;
                    rem_q           <= rem_nxt;
                end else begin
                    acc_q <= mul_nxt;
                end
            end
            if (state == FIX && !flush)
                result <= fix_val;
        end
    end
endmodule
